// File: rtl/data_mem_stage.sv
`default_nettype none
// ============================================================================
// data_mem_stage: MEM-stage byte-addressed little-endian data RAM with fixed
// multi-cycle latency, LDUR/STUR sizes, sign/zero extension and a pipeline stall.
// Revision: 1.0
// ============================================================================
module data_mem_stage #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        fault
);

  localparam int ADDR_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       read_data_q, read_data_d;
  logic [7:0]        mem_q [DEPTH_BYTES];

  logic              req;
  logic              illegal;
  logic              misaligned;
  logic              out_of_range;
  logic [3:0]        nbytes;
  logic [63:0]       align_mask;
  logic [ADDR_W-1:0] base;
  logic [63:0]       raw;
  logic [63:0]       loaded;
  logic              commit;
  logic              stall_w;
  logic              done_w;
  logic              fault_w;

  assign req          = mem_read | mem_write;
  assign nbytes       = 4'd1 << size;
  assign align_mask   = {60'd0, nbytes - 4'd1};
  assign misaligned   = |(address & align_mask);
  assign out_of_range = address >= 64'(DEPTH_BYTES);
  assign illegal      = misaligned | out_of_range | (mem_read & mem_write);
  assign base         = address[ADDR_W-1:0];

  // Accepted accesses are aligned and in range, so base+i never wraps for i < nbytes.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) begin
        raw[8*i +: 8] = mem_q[base + ADDR_W'(i)];
      end
    end
  end

  always_comb begin
    loaded = raw;
    unique case (size)
      2'b00:   loaded = {{56{sign_ext & raw[7]}},  raw[7:0]};
      2'b01:   loaded = {{48{sign_ext & raw[15]}}, raw[15:0]};
      2'b10:   loaded = {{32{sign_ext & raw[31]}}, raw[31:0]};
      default: loaded = raw;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    stall_w     = 1'b0;
    done_w      = 1'b0;
    fault_w     = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        fault_w = req & illegal;
        if (req & ~illegal) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
          stall_w = 1'b1;
        end
      end
      S_BUSY: begin
        stall_w = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (mem_write) begin
            commit = 1'b1;
          end else begin
            read_data_d = loaded;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        done_w  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
    end
  end

  // RAM is not reset; a reset in the commit cycle suppresses the write.
  always_ff @(posedge clock) begin
    if (commit & ~reset) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) begin
          mem_q[base + ADDR_W'(i)] <= write_data[8*i +: 8];
        end
      end
    end
  end

  assign read_data = read_data_q;
  assign stall     = stall_w & ~reset;
  assign done      = done_w  & ~reset;
  assign fault     = fault_w & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_data_mem_stage: directed self-checking bench for data_mem_stage
// (LATENCY=2, DEPTH_BYTES=1024). Revision: 1.0
// ============================================================================
module tb_data_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        stall;
  logic        done;
  logic        fault;

  int tests  = 0;
  int errors = 0;

  data_mem_stage #(.DEPTH_BYTES(1024), .LATENCY(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .sign_ext   (sign_ext),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .done       (done),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Issue one legal access; checks latency (done in cycle 4) and stall in cycles 1..3.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic sx,
                           input logic [63:0] a, input logic [63:0] wd);
    int          dcyc;
    logic [15:0] sbits;
    dcyc  = 0;
    sbits = '0;
    @(negedge clock);
    mem_read   = rd;
    mem_write  = wr;
    size       = sz;
    sign_ext   = sx;
    address    = a;
    write_data = wd;
    for (int c = 1; c <= 16 && dcyc == 0; c++) begin
      #1;
      if (stall) sbits[c-1] = 1'b1;
      if (done) dcyc = c;
      else begin
        @(posedge clock);
        @(negedge clock);
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check({tag, "_done_cycle"}, 64'(dcyc), 64'd4);
    check({tag, "_stall_cycles"}, 64'(sbits), 64'h7);
  endtask

  // Hold an illegal request for several cycles: fault immediate, no stall, no done.
  task automatic fault_req(input string tag, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic [63:0] a);
    int ndone;
    int nstall;
    ndone  = 0;
    nstall = 0;
    @(negedge clock);
    mem_read  = rd;
    mem_write = wr;
    size      = sz;
    sign_ext  = 1'b0;
    address   = a;
    #1;
    check({tag, "_fault"}, 64'(fault), 64'd1);
    for (int c = 0; c < 5; c++) begin
      if (done) ndone++;
      if (stall) nstall++;
      @(posedge clock);
      @(negedge clock);
      #1;
    end
    check({tag, "_done_count"}, 64'(ndone), 64'd0);
    check({tag, "_stall_count"}, 64'(nstall), 64'd0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    size       = 2'b11;
    sign_ext   = 1'b0;
    address    = 64'd4;
    write_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_read_data", read_data, 64'd0);
    mem_read = 1'b0;
    reset    = 1'b0;

    // Dword store then load
    do_access("t1_stur", 1'b0, 1'b1, 2'b11, 1'b0, 64'd8, 64'h1122334455667788);
    check("t1_store_rd_unchanged", read_data, 64'd0);
    do_access("t1_ldur", 1'b1, 1'b0, 2'b11, 1'b0, 64'd8, 64'd0);
    check("t1_ldur_data", read_data, 64'h1122334455667788);

    // Narrow loads and extension
    do_access("t2_ldurb8", 1'b1, 1'b0, 2'b00, 1'b0, 64'd8, 64'd0);
    check("t2_ldurb8_data", read_data, 64'h88);
    do_access("t2_ldursb8", 1'b1, 1'b0, 2'b00, 1'b1, 64'd8, 64'd0);
    check("t2_ldursb8_data", read_data, 64'hFFFFFFFFFFFFFF88);
    do_access("t2_ldurb15", 1'b1, 1'b0, 2'b00, 1'b1, 64'd15, 64'd0);
    check("t2_ldurb15_data", read_data, 64'h11);
    do_access("t2_sturh", 1'b0, 1'b1, 2'b01, 1'b0, 64'd16, 64'h0000_0000_0000_8001);
    check("t2_sturh_rd_unchanged", read_data, 64'h11);
    do_access("t2_ldursh", 1'b1, 1'b0, 2'b01, 1'b1, 64'd16, 64'd0);
    check("t2_ldursh_data", read_data, 64'hFFFFFFFFFFFF8001);
    do_access("t2_ldurh", 1'b1, 1'b0, 2'b01, 1'b0, 64'd16, 64'd0);
    check("t2_ldurh_data", read_data, 64'h0000000000008001);

    // Illegal requests
    fault_req("t3_misaligned", 1'b1, 1'b0, 2'b11, 64'd4);
    fault_req("t3_range", 1'b1, 1'b0, 2'b00, 64'd1024);
    fault_req("t3_range_hi", 1'b1, 1'b0, 2'b00, 64'h8000_0000_0000_0008);
    fault_req("t3_both", 1'b1, 1'b1, 2'b11, 64'd8);
    fault_req("t3_half_odd", 1'b0, 1'b1, 2'b01, 64'd17);
    check("t3_rd_unchanged", read_data, 64'h0000000000008001);
    do_access("t3_ldur", 1'b1, 1'b0, 2'b11, 1'b0, 64'd8, 64'd0);
    check("t3_ldur_data", read_data, 64'h1122334455667788);
    do_access("t3_ldurh_after", 1'b1, 1'b0, 2'b01, 1'b0, 64'd16, 64'd0);
    check("t3_ldurh_after_data", read_data, 64'h8001);

    // Reset during the first BUSY cycle of a store
    @(negedge clock);
    mem_write  = 1'b1;
    size       = 2'b11;
    address    = 64'd8;
    write_data = 64'hAAAAAAAAAAAAAAAA;
    #1;
    check("t4_stall_c1", 64'(stall), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("t4_stall_in_reset", 64'(stall), 64'd0);
    @(negedge clock);
    reset     = 1'b0;
    mem_write = 1'b0;
    #1;
    check("t4_stall_after", 64'(stall), 64'd0);
    check("t4_read_data_after", read_data, 64'd0);
    do_access("t4_ldur", 1'b1, 1'b0, 2'b11, 1'b0, 64'd8, 64'd0);
    check("t4_ldur_data", read_data, 64'h1122334455667788);

    // Word store followed immediately by a sign-extending word load
    do_access("t5_stur_pre", 1'b0, 1'b1, 2'b11, 1'b0, 64'd32, 64'h0123456789ABCDEF);
    do_access("t5_sturw", 1'b0, 1'b1, 2'b10, 1'b0, 64'd32, 64'h55555555CAFEBABE);
    do_access("t5_ldursw", 1'b1, 1'b0, 2'b10, 1'b1, 64'd32, 64'd0);
    check("t5_ldursw_data", read_data, 64'hFFFFFFFFCAFEBABE);
    do_access("t5_ldurw", 1'b1, 1'b0, 2'b10, 1'b0, 64'd32, 64'd0);
    check("t5_ldurw_data", read_data, 64'h00000000CAFEBABE);
    do_access("t5_ldur", 1'b1, 1'b0, 2'b11, 1'b0, 64'd32, 64'd0);
    check("t5_ldur_data", read_data, 64'h01234567CAFEBABE);
    do_access("t5_top", 1'b0, 1'b1, 2'b11, 1'b0, 64'd1016, 64'hDEADBEEF00C0FFEE);
    do_access("t5_top_ld", 1'b1, 1'b0, 2'b11, 1'b0, 64'd1016, 64'd0);
    check("t5_top_data", read_data, 64'hDEADBEEF00C0FFEE);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
